multicycle_ctrl: RTL and testbench

//  Main controller FSM for the multicycle MIPS core. Sequences the shared datapath
//  (PC, IR, register file, ALU, single unified memory) one instruction at a time.

---
 rtl/mips_ctrl_pkg.sv | 82 ++++++++
 rtl/multicycle_aludec.sv | 30 +++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: state codes,
// opcode/funct values, ALU codes and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop NONE yields alucontrol 000 so idle states drive all-zero controls
  localparam logic [1:0] ALUOP_NONE  = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
  } ctrl_t;

endpackage

// File: rtl/multicycle_aludec.sv
// ALU decoder: maps the controller's aluop class plus the R-type funct field
// onto the 3-bit ALU control code.
module multicycle_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main controller FSM for the multicycle MIPS core: sequences the shared datapath,
// stalls on mem_ready and bounds every memory wait with a sticky-error timeout.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       mem_err,
  output logic [3:0] state_o
);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   waitcnt_q, waitcnt_d;
  logic                mem_err_q, mem_err_d;
  logic                is_wait, timeout;
  ctrl_t               c, co;

  always_comb begin
    is_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout   = is_wait && !mem_ready && (waitcnt_q == WAIT_W'(MAX_WAIT));
    mem_err_d = mem_err_q | timeout;
    waitcnt_d = '0;
    // counter only runs while stalled; any exit (ready or timeout) leaves it at zero
    if (is_wait && !mem_ready && !timeout) waitcnt_d = waitcnt_q + WAIT_W'(1);

    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
      S_MEMWR:  if (mem_ready || timeout) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      waitcnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.memread = 1'b1;
        if (mem_ready) begin
          c.irwrite = 1'b1;
          c.pcen    = 1'b1;
          c.alusrcb = SRCB_FOUR;
          c.aluop   = ALUOP_ADD;
          c.pcsrc   = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regdst   = RDST_RT;
        c.memtoreg = M2R_MDR;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = RDST_RD;
        c.memtoreg = M2R_ALUOUT;
        c.regwrite = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.pcen    = zero;
      end
      S_ADDIWB: begin
        c.regdst   = RDST_RT;
        c.memtoreg = M2R_ALUOUT;
        c.regwrite = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc = PCSRC_JUMP;
        c.pcen  = 1'b1;
      end
      S_JAL: begin
        c.pcsrc    = PCSRC_JUMP;
        c.pcen     = 1'b1;
        c.regdst   = RDST_RA;
        c.memtoreg = M2R_PC;
        c.regwrite = 1'b1;
      end
      S_JR: begin
        c.pcsrc = PCSRC_REGA;
        c.pcen  = 1'b1;
      end
      default: c = '0;
    endcase
  end

  // strobes must fall the moment reset asserts, not at the next clock edge
  assign co = reset ? c : '0;

  multicycle_aludec u_aludec (
    .aluop      (co.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign memread  = co.memread;
  assign memwrite = co.memwrite;
  assign iord     = co.iord;
  assign irwrite  = co.irwrite;
  assign pcen     = co.pcen;
  assign pcsrc    = co.pcsrc;
  assign alusrca  = co.alusrca;
  assign alusrcb  = co.alusrcb;
  assign regdst   = co.regdst;
  assign memtoreg = co.memtoreg;
  assign regwrite = co.regwrite;
  assign mem_err  = mem_err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction walks with literal expectations,
// then randomized inputs checked every cycle against a behavioural model.
module tb_multicycle_ctrl;

  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       memread, memwrite, iord, irwrite, pcen, alusrca, regwrite, mem_err;
  logic [1:0] pcsrc, alusrcb, regdst, memtoreg;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  int n_tests = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(MW), .WAIT_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .mem_err(mem_err),
    .state_o(state_o)
  );

  wire [22:0] dut_vec = {memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                         alucontrol, regdst, memtoreg, regwrite, mem_err, state_o};

  // ---------------- behavioural model ----------------
  int m_st = 0, m_wc = 0;
  bit m_err = 1'b0;

  function automatic logic [2:0] alu_of_funct(logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [22:0] model_out(int st, logic [5:0] f, logic z, logic mr, bit err);
    logic rd, wr, ad, irw, pce, asa, rw;
    logic [1:0] pcs, asb, rdst, m2r;
    logic [2:0] alu;
    {rd, wr, ad, irw, pce, asa, rw} = '0;
    {pcs, asb, rdst, m2r} = '0;
    alu = 3'b000;
    case (st)
      0:  begin rd = 1; if (mr) begin irw = 1; pce = 1; asb = 2'b01; alu = 3'b010; end end
      1:  begin asb = 2'b11; alu = 3'b010; end
      2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      3:  begin rd = 1; ad = 1; end
      4:  begin m2r = 2'b01; rw = 1; end
      5:  begin wr = 1; ad = 1; end
      6:  begin asa = 1; alu = alu_of_funct(f); end
      7:  begin rdst = 2'b01; rw = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pce = z; end
      9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      10: rw = 1;
      11: begin pcs = 2'b10; pce = 1; end
      12: begin pcs = 2'b10; pce = 1; rdst = 2'b10; m2r = 2'b10; rw = 1; end
      13: begin pcs = 2'b11; pce = 1; end
      default: ;
    endcase
    return {rd, wr, ad, irw, pce, pcs, asa, asb, alu, rdst, m2r, rw, err, 4'(st)};
  endfunction

  function automatic int decode_next(logic [5:0] o, logic [5:0] f);
    case (o)
      6'b100011, 6'b101011: return 2;
      6'b000000:            return (f == 6'b001000) ? 13 : 6;
      6'b000100:            return 8;
      6'b001000:            return 9;
      6'b000010:            return 11;
      6'b000011:            return 12;
      default:              return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [22:0] e;
    int nxt;
    if (cmp_en) begin
      if (!reset) begin
        e = '0;
        m_st = 0; m_wc = 0; m_err = 1'b0;
      end else begin
        e = model_out(m_st, funct, zero, mem_ready, m_err);
        if (m_st == 0 || m_st == 3 || m_st == 5) begin
          if (mem_ready) begin
            nxt = (m_st == 0) ? 1 : (m_st == 3) ? 4 : 0;
            m_wc = 0;
          end else if (m_wc == MW) begin
            nxt = 0; m_wc = 0; m_err = 1'b1;
          end else begin
            nxt = m_st; m_wc++;
          end
        end else begin
          m_wc = 0;
          case (m_st)
            1:       nxt = decode_next(op, funct);
            2:       nxt = (op == 6'b100011) ? 3 : 5;
            6:       nxt = 7;
            9:       nxt = 10;
            default: nxt = 0;
          endcase
        end
        m_st = nxt;
      end
      n_tests++;
      if (dut_vec !== e) begin
        n_fail++;
        $display("FAIL model t=%0t: got %h exp %h", $time, dut_vec, e);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pick_op(int k);
    case (k)
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'b000011;
      7: return 6'b111111;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [5:0] pick_funct(int k);
    case (k)
      0: return 6'h20;
      1: return 6'h22;
      2: return 6'h24;
      3: return 6'h25;
      4: return 6'h2a;
      5: return 6'h08;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    // reset held for 3 cycles: everything low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", 32'(dut_vec), 32'h0);
    end
    op = 6'b100011; mem_ready = 1'b1;
    tick(); reset = 1'b1;

    // lw walk
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lw_state", 32'(state_o), 32'(i));
      if (i == 0) chk("fetch_strobes", 32'({memread, irwrite, pcen}), 32'b111);
      if (i == 4) chk("memwb_ctl", 32'({regwrite, memtoreg, regdst}), 32'b1_01_00);
    end

    // sw with 3 stall cycles
    tick(); op = 6'b101011;
    @(negedge clk); chk("sw_fetch", 32'(state_o), 32'd0);
    tick();
    tick(); mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) mem_ready = 1'b1;
      @(negedge clk);
      chk("sw_memwr", 32'({state_o, memwrite, iord, regwrite}), {25'd0, 4'd5, 3'b110});
    end
    tick(); op = 6'b000100; zero = 1'b1;
    @(negedge clk); chk("sw_done", 32'(state_o), 32'd0);

    // beq taken, beq not taken, jal
    tick(); tick();
    @(negedge clk); chk("beq_z1", 32'({state_o, alucontrol, pcsrc, pcen}), {22'd0, 4'd8, 3'b110, 2'b01, 1'b1});
    tick(); zero = 1'b0;
    tick(); tick();
    @(negedge clk); chk("beq_z0", 32'({state_o, pcen}), {27'd0, 4'd8, 1'b0});
    tick(); op = 6'b000011;
    tick(); tick();
    @(negedge clk); chk("jal", 32'({state_o, regdst, memtoreg, pcsrc}), {22'd0, 4'd12, 2'b10, 2'b10, 2'b10});

    // slt then jr
    tick(); op = 6'b000000; funct = 6'b101010;
    tick(); tick();
    @(negedge clk); chk("exec_slt", 32'({state_o, alucontrol}), {25'd0, 4'd6, 3'b111});
    tick();
    @(negedge clk); chk("aluwb", 32'({state_o, regdst, regwrite}), {25'd0, 4'd7, 2'b01, 1'b1});
    tick(); funct = 6'b001000;
    tick(); tick();
    @(negedge clk); chk("jr", 32'({state_o, pcsrc, pcen, regwrite}), {24'd0, 4'd13, 2'b11, 1'b1, 1'b0});

    // fetch timeout with MAX_WAIT=4
    tick(); mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("to_wait", 32'({state_o, pcen, mem_err}), 32'd0);
      tick();
    end
    @(negedge clk); chk("to_fire", 32'({state_o, pcen, mem_err, memread}), {26'd0, 4'd0, 1'b0, 1'b1, 1'b1});
    tick(); mem_ready = 1'b1; op = 6'b001000;
    @(negedge clk); chk("err_sticky", 32'({state_o, mem_err}), {27'd0, 4'd0, 1'b1});
    tick(); tick();
    @(negedge clk); chk("addiex", 32'({state_o, alusrca, alusrcb, alucontrol}), {22'd0, 4'd9, 1'b1, 2'b10, 3'b010});

    // asynchronous reset in ADDIWB, checked between clock edges
    tick(); #1;
    chk("addiwb_rw", 32'({regwrite, mem_err}), 32'b11);
    reset = 1'b0;
    #1 chk("async_rst", 32'(dut_vec), 32'h0);
    @(negedge clk);
    tick(); reset = 1'b1;
    @(negedge clk); chk("err_cleared", 32'(mem_err), 32'd0);

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      tick();
      op        = pick_op($urandom_range(0, 8));
      funct     = pick_funct($urandom_range(0, 6));
      zero      = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 9) < (((n / 60) % 3 == 0) ? 3 : 8));
      reset     = ($urandom_range(0, 299) != 0);
    end
    tick(); reset = 1'b0;
    @(negedge clk); chk("final_rst", 32'({mem_err, state_o}), 32'd0);
    tick(); reset = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
